// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } mult_state_t;

   localparam int MULT_WIDTH = 32;
   localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

endpackage

// File: rtl/zero.sv
// Cascade zero detector: walks the vector MSB to LSB and reports all-zero.
module zero #(
   parameter int WIDTH = 32
) (
   input  logic [0:WIDTH-1] data_i,
   output logic             zero_o
);

   logic allZero;

   always_comb begin
      allZero = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         allZero = allZero & ~data_i[i];
      end
   end

   assign zero_o = allZero;

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, one multiplier bit per clock with early exit
// once the remaining multiplier bits are all zero.
module mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signed_op,
   input  logic [0:WIDTH-1]     a,
   input  logic [0:WIDTH-1]     b,
   output logic                 busy,
   output logic                 stall,
   output logic                 done,
   output logic [0:2*WIDTH-1]   product
);

   localparam int CW = $clog2(WIDTH);

   mult_state_t state_q, state_d;

   logic [0:2*WIDTH-1] acc_q, acc_d;
   logic [0:2*WIDTH-1] mcand_q, mcand_d;
   logic [0:WIDTH-1]   mplier_q, mplier_d;
   logic [0:CW-1]      count_q, count_d;
   logic               neg_q, neg_d;
   logic [0:2*WIDTH-1] product_q, product_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [0:WIDTH-1]   magA, magB;
   logic [0:WIDTH-1]   mplierShift;
   logic [0:2*WIDTH-1] accNext;
   logic               mplierZero;

   assign mplierShift = mplier_q >> 1;

   zero #(.WIDTH(WIDTH)) uZero (
      .data_i (mplierShift),
      .zero_o (mplierZero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state and datapath; bit 0 is the MSB, so the sign is a[0].
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      neg_d     = neg_q;
      product_d = product_q;
      magA      = (signed_op && a[0]) ? (~a + 1'b1) : a;
      magB      = (signed_op && b[0]) ? (~b + 1'b1) : b;
      accNext   = mplier_q[WIDTH-1] ? (acc_q + mcand_q) : acc_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, magA};
               mplier_d = magB;
               acc_d    = '0;
               neg_d    = signed_op & (a[0] ^ b[0]);
               count_d  = '0;
               if (magB == '0) begin
                  state_d   = DONE;
                  product_d = '0;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            acc_d    = accNext;
            mcand_d  = mcand_q << 1;
            mplier_d = mplierShift;
            count_d  = count_q + CW'(1);
            if (mplierZero || (count_q == CW'(WIDTH - 1))) begin
               state_d   = DONE;
               product_d = neg_q ? (~accNext + 1'b1) : accNext;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
      stall  = busy_q | (start & (state_q == IDLE));
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: reference product/latency model plus directed jobs.
module tb_mult_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        signed_op = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        stall;
   logic        done;
   logic [63:0] product;

   int total = 0;
   int bad = 0;

   int          busyLeft = 0;
   logic [63:0] expProduct = '0;
   logic [63:0] pendProduct = '0;

   mult_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .signed_op (signed_op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .stall     (stall),
      .done      (done),
      .product   (product)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] magOf(input logic [31:0] v, input logic sop);
      return (sop && v[31]) ? (32'd0 - v) : v;
   endfunction

   function automatic int bitLen(input logic [31:0] v);
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) return i + 1;
      end
      return 0;
   endfunction

   function automatic logic [63:0] refProd(input logic sop, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      if (sop) return 64'(sx * sy);
      return {32'd0, x} * {32'd0, y};
   endfunction

   // Model: a job occupies bitLen(|b|)+1 cycles, the last one showing done.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         busyLeft    <= 0;
         expProduct  <= '0;
         pendProduct <= '0;
      end else if (busyLeft == 0) begin
         if (start) begin
            busyLeft    <= bitLen(magOf(b, signed_op)) + 1;
            pendProduct <= refProd(signed_op, a, b);
            if (bitLen(magOf(b, signed_op)) == 0) expProduct <= refProd(signed_op, a, b);
         end
      end else begin
         busyLeft <= busyLeft - 1;
         if (busyLeft == 2) expProduct <= pendProduct;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic compareLoop();
      forever begin
         @(negedge clk);
         if (!reset) begin
            checkOutput("cyc_busy", 64'(busy), 64'(busyLeft > 0));
            checkOutput("cyc_done", 64'(done), 64'(busyLeft == 1));
            checkOutput("cyc_stall", 64'(stall), 64'((busyLeft > 0) || start));
            checkOutput("cyc_product", product, expProduct);
         end
      end
   endtask

   task automatic applyStimulus(input logic sop, input logic [31:0] av, input logic [31:0] bv,
                                input bit inject, output int latency, output int stallCycles,
                                output int donePulses);
      bit seen;
      @(posedge clk); #1;
      signed_op = sop; a = av; b = bv; start = 1'b1;
      @(negedge clk);
      stallCycles = stall ? 1 : 0;
      @(posedge clk); #1;
      start = 1'b0;
      latency = 0;
      donePulses = 0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            if (inject && k >= 2 && k <= 9) begin
               start = k[0];
               a = $urandom;
               b = $urandom;
               signed_op = ~signed_op;
            end else if (inject && k == 10) begin
               start = 1'b0;
            end
         end
         @(negedge clk);
         latency++;
         if (stall) stallCycles++;
         if (done) begin
            seen = 1'b1;
            donePulses++;
         end
      end
      if (!seen) latency = -1;
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) donePulses++;
      end
   endtask

   initial begin
      int lat, stl, dp;
      fork
         compareLoop();
      join_none

      #3;
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_product", product, 64'd0);
      checkOutput("rst_stall_lo", 64'(stall), 64'd0);
      start = 1'b1;
      #1;
      checkOutput("rst_stall_hi", 64'(stall), 64'd1);
      start = 1'b0;
      #8;
      reset = 1'b0;

      applyStimulus(1'b0, 32'd3, 32'd5, 1'b0, lat, stl, dp);
      checkOutput("u3x5_product", product, 64'd15);
      checkOutput("u3x5_latency", 64'(lat), 64'd4);
      checkOutput("u3x5_stall", 64'(stl), 64'd5);

      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, lat, stl, dp);
      checkOutput("bzero_product", product, 64'd0);
      checkOutput("bzero_latency", 64'(lat), 64'd1);

      applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd6, 1'b0, lat, stl, dp);
      checkOutput("sm7x6_product", product, 64'hFFFF_FFFF_FFFF_FFD6);
      checkOutput("sm7x6_latency", 64'(lat), 64'd4);

      applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, stl, dp);
      checkOutput("smin2_product", product, 64'h4000_0000_0000_0000);
      checkOutput("smin2_latency", 64'(lat), 64'd33);

      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, stl, dp);
      checkOutput("umax_product", product, 64'hFFFF_FFFE_0000_0001);
      checkOutput("umax_latency", 64'(lat), 64'd33);
      checkOutput("umax_done_pulses", 64'(dp), 64'd1);

      @(posedge clk); #1;
      signed_op = 1'b0; a = 32'd1; b = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_done", 64'(done), 64'd0);
      checkOutput("midrst_product", product, 64'd0);
      checkOutput("midrst_stall", 64'(stall), 64'd0);
      start = 1'b1;
      #1;
      checkOutput("midrst_stall_start", 64'(stall), 64'd1);
      start = 1'b0;
      @(negedge clk); #1;
      reset = 1'b0;

      applyStimulus(1'b0, 32'd2, 32'd2, 1'b0, lat, stl, dp);
      checkOutput("u2x2_product", product, 64'd4);
      checkOutput("u2x2_latency", 64'(lat), 64'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
